multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle main controller, the decode side of the datapath's Op/Func/control interface.
//  Sits beside the datapath: consumes Op/Func from the fetched instruction plus ALU Zero.
//  Sequences each instruction through IF/ID/EX/MEM/WB and drives the 3-bit control buses.
//  Also drives the IR/PC/register/memory write strobes, one commit per instruction.
// PARAMETERS
//  CNT_W  32  width of the retired-instruction counter
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-low reset (0 = reset)
//  Op           in   6      instr[31:26] from datapath IR
//  Func         in   6      instr[5:0] from datapath IR
//  Zero         in   1      ALU equality flag; informational, NPC resolves beq itself
//  ALUSrc       out  3      0=RD2, 1=Imm32
//  ExtOp        out  3      0=zero-ext, 1=sign-ext, 2=imm<<16
//  ALUControl   out  3      0=add, 1=sub, 2=or
//  RegWrite     out  3      1=GRF write strobe, else 0
//  MemWrite     out  3      1=DM write strobe, else 0
//  RegDst       out  3      0=rt, 1=rd, 2=$31
//  nPCSel       out  3      0=PC+4, 1=beq, 2=j/jal, 3=jr
//  RegWriteSel  out  3      0=ALURe, 1=LoadData, 2=PC+4
//  DataExtOp    out  3      0=word (only value driven)
//  ir_we        out  1      IR load strobe
//  pc_we        out  1      PC update strobe
//  state        out  3      IF=0, ID=1, EX=2, MEM=3, WB=4
//  retired      out  CNT_W  instructions committed since reset
//  illegal      out  1      one-cycle pulse on undecodable instruction
// BEHAVIOUR
//  - Reset (reset==0, async): state=IF, decode reg=nop, retired=0, illegal=0.
//    All strobes (ir_we, pc_we, RegWrite, MemWrite) forced 0 while reset==0.
//    All control buses read 0 during reset.
//  - Decode register: Op/Func captured at the end of ID; EX/MEM/WB use only this copy.
//  - Supported set: addu(0/21), subu(0/23), jr(0/08), nop(0/00), ori(0d), lui(0f),
//    lw(23), sw(2b), beq(04), j(02), jal(03).
//  - State sequences (one state per cycle):
//      addu/subu/ori/lui:  IF ID EX WB   (4 cyc)
//      lw:                 IF ID EX MEM WB (5)
//      sw:                 IF ID EX MEM  (4)
//      beq/j/jr/nop:       IF ID EX      (3)
//      jal:                IF ID EX WB   (4)
//    Last state of each sequence returns to IF.
//  - Strobes:
//      ir_we=1 only in IF.
//      pc_we=1 only in the last state, with nPCSel valid in that same cycle.
//      RegWrite=1 only in WB.
//      MemWrite=1 only in MEM for sw; lw MEM keeps MemWrite=0.
//      Exactly one pc_we pulse per instruction.
//  - Buses hold their decoded values from EX through the final state; in IF/ID all buses are 0.
//  - retired increments by 1 on every pc_we cycle; wraps modulo 2^CNT_W.
//  - Unsupported Op/Func: executes as nop (IF ID EX, nPCSel=0, no writes).
//    illegal=1 in that EX cycle only; retired still increments.
//  - reset asserted mid-instruction: aborts immediately, no partial write.
//    After release, the first cycle is IF.
// TESTING
//  - Reset mid-lw MEM -> state=0, pc_we=0, RegWrite=0; after release ir_we=1 next cycle.
//  - addu (Op=00, Func=21) -> states 0,1,2,4, then RegWrite=1, RegDst=1, ALUControl=0,
//    RegWriteSel=0, pc_we=1 in WB; retired 0->1.
//  - lw (Op=23) -> 5 cycles; MEM: MemWrite=0. WB: RegWrite=1, RegDst=0, RegWriteSel=1,
//    ExtOp=1, ALUSrc=1.
//  - sw then beq (Op=2b, 04) -> sw: MemWrite=1 one cycle in MEM, RegWrite=0.
//    beq: EX pc_we=1, nPCSel=1, ALUControl=1, 3 cycles.
//  - jal (Op=03) then jr (Op=00, Func=08) -> jal: WB RegDst=2, RegWriteSel=2, nPCSel=2.
//    jr: EX nPCSel=3, RegWrite=0.
//  - Op=3f -> illegal pulses 1 cycle in EX, nPCSel=0, no writes.
//    With CNT_W=4 and 16 instructions retired, retired wraps 15->0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller: steps each instruction through IF/ID/EX/MEM/WB and
// drives the datapath control buses, write strobes and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Func,
  input  logic             Zero,
  output logic [2:0]       ALUSrc,
  output logic [2:0]       ExtOp,
  output logic [2:0]       ALUControl,
  output logic [2:0]       RegWrite,
  output logic [2:0]       MemWrite,
  output logic [2:0]       RegDst,
  output logic [2:0]       nPCSel,
  output logic [2:0]       RegWriteSel,
  output logic [2:0]       DataExtOp,
  output logic             ir_we,
  output logic             pc_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_NOP, I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL
  } instr_t;

  state_t cur_state, next_state, last_state;
  instr_t kind;
  logic [5:0] dop, dfunc;
  logic bad;
  logic exec_phase;
  logic [2:0] d_alusrc, d_extop, d_aluctl, d_regdst, d_npcsel, d_regwritesel;

  // Zero is informational only; the NPC unit resolves beq on its own.
  logic unused_zero;
  assign unused_zero = Zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= S_IF;
    end else begin
      cur_state <= next_state;
    end
  end

  // Op/Func are latched as ID ends so the datapath may reload IR without disturbing EX..WB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dop   <= 6'h00;
      dfunc <= 6'h00;
    end else if (cur_state == S_ID) begin
      dop   <= Op;
      dfunc <= Func;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if (pc_we) begin
      retired <= retired + CNT_W'(1);
    end
  end

  // Anything outside the supported set decodes as a nop and is flagged.
  always_comb begin
    kind = I_NOP;
    bad  = 1'b0;
    case (dop)
      6'h00: begin
        case (dfunc)
          6'h21:   kind = I_ADDU;
          6'h23:   kind = I_SUBU;
          6'h08:   kind = I_JR;
          6'h00:   kind = I_NOP;
          default: bad  = 1'b1;
        endcase
      end
      6'h0d:   kind = I_ORI;
      6'h0f:   kind = I_LUI;
      6'h23:   kind = I_LW;
      6'h2b:   kind = I_SW;
      6'h04:   kind = I_BEQ;
      6'h02:   kind = I_J;
      6'h03:   kind = I_JAL;
      default: bad  = 1'b1;
    endcase
  end

  always_comb begin
    d_alusrc      = 3'd0;
    d_extop       = 3'd0;
    d_aluctl      = 3'd0;
    d_regdst      = 3'd0;
    d_npcsel      = 3'd0;
    d_regwritesel = 3'd0;
    last_state    = S_EX;
    case (kind)
      I_ADDU: begin
        d_regdst   = 3'd1;
        last_state = S_WB;
      end
      I_SUBU: begin
        d_aluctl   = 3'd1;
        d_regdst   = 3'd1;
        last_state = S_WB;
      end
      I_ORI: begin
        d_alusrc   = 3'd1;
        d_aluctl   = 3'd2;
        last_state = S_WB;
      end
      I_LUI: begin
        d_alusrc   = 3'd1;
        d_extop    = 3'd2;
        last_state = S_WB;
      end
      I_LW: begin
        d_alusrc      = 3'd1;
        d_extop       = 3'd1;
        d_regwritesel = 3'd1;
        last_state    = S_WB;
      end
      I_SW: begin
        d_alusrc   = 3'd1;
        d_extop    = 3'd1;
        last_state = S_MEM;
      end
      I_BEQ: begin
        d_aluctl = 3'd1;
        d_npcsel = 3'd1;
      end
      I_J:  d_npcsel = 3'd2;
      I_JR: d_npcsel = 3'd3;
      I_JAL: begin
        d_npcsel      = 3'd2;
        d_regdst      = 3'd2;
        d_regwritesel = 3'd2;
        last_state    = S_WB;
      end
      default: ;
    endcase
  end

  always_comb begin
    next_state = S_IF;
    case (cur_state)
      S_IF: next_state = S_ID;
      S_ID: next_state = S_EX;
      S_EX: begin
        if (last_state == S_EX)       next_state = S_IF;
        else if (last_state == S_MEM) next_state = S_MEM;
        else if (kind == I_LW)        next_state = S_MEM;
        else                          next_state = S_WB;
      end
      S_MEM: next_state = (kind == I_LW) ? S_WB : S_IF;
      S_WB:  next_state = S_IF;
      default: next_state = S_IF;
    endcase
  end

  // Every output is qualified by reset so nothing strobes while reset is held low.
  always_comb begin
    exec_phase  = reset && (cur_state == S_EX || cur_state == S_MEM || cur_state == S_WB);
    ALUSrc      = exec_phase ? d_alusrc      : 3'd0;
    ExtOp       = exec_phase ? d_extop       : 3'd0;
    ALUControl  = exec_phase ? d_aluctl      : 3'd0;
    RegDst      = exec_phase ? d_regdst      : 3'd0;
    nPCSel      = exec_phase ? d_npcsel      : 3'd0;
    RegWriteSel = exec_phase ? d_regwritesel : 3'd0;
    DataExtOp   = 3'd0;
    RegWrite    = {2'b00, reset && cur_state == S_WB};
    MemWrite    = {2'b00, reset && cur_state == S_MEM && kind == I_SW};
    ir_we       = reset && cur_state == S_IF;
    pc_we       = exec_phase && cur_state == last_state;
    illegal     = reset && cur_state == S_EX && bad;
    state       = cur_state;
  end

endmodule
